// File: rtl/c_hazard_controller.sv
// Hazard, forwarding and multi-cycle sequencing control for the five-stage core.
// Optional stall-cycle performance counter enabled with `define HAZ_PERF_CNT_EN.
module c_hazard_controller #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWE_W_E,
  input  logic             RegWE_M,
  input  logic             RegWE_W,
  input  logic             LoadM,
  input  logic             branch_taken_E,
  input  logic             mc_start_E,
  input  logic             mc_done,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mc_go,
  output logic             mc_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  localparam int BW = $clog2(MC_TIMEOUT) + 1;
  localparam logic [BW-1:0] LAST_CNT = BW'(MC_TIMEOUT - 1);

  typedef enum logic {RUN, MC_BUSY} state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  busy_cnt_q, busy_cnt_d;
  logic           timeout_q, timeout_d;
  logic           lu_d, lu_e;

  // M result wins over W; a load in M has no value yet so it never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic we_m,
                                         input logic ld_m, input logic [4:0] rd_m,
                                         input logic we_w, input logic [4:0] rd_w);
    if (we_m && !ld_m && rd_m != 5'd0 && rd_m == rs) return 2'b10;
    else if (we_w && rd_w != 5'd0 && rd_w == rs)     return 2'b01;
    else                                             return 2'b00;
  endfunction

  assign lu_d = RegWE_W_E && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
  assign lu_e = LoadM && RegWE_M && RdM != 5'd0 && (RdM == Rs1E || RdM == Rs2E);

  always_comb begin
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushM     = 1'b0;
    ForwardAE  = 2'b00;
    ForwardBE  = 2'b00;
    mc_go      = 1'b0;
    mc_timeout = 1'b0;
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    timeout_d  = timeout_q;
    // Outputs are forced quiet for as long as reset is held low.
    if (reset) begin
      mc_timeout = timeout_q;
      ForwardAE  = fwd_sel(Rs1E, RegWE_M, LoadM, RdM, RegWE_W, RdW);
      ForwardBE  = fwd_sel(Rs2E, RegWE_M, LoadM, RdM, RegWE_W, RdW);
      case (state_q)
        RUN: begin
          if (branch_taken_E) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (lu_e) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
          end else if (mc_start_E) begin
            mc_go      = 1'b1;
            StallF     = 1'b1;
            StallD     = 1'b1;
            StallE     = 1'b1;
            FlushM     = 1'b1;
            state_d    = MC_BUSY;
            busy_cnt_d = '0;
          end else if (lu_d) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
        MC_BUSY: begin
          if (mc_done) begin
            state_d = RUN;
          end else if (busy_cnt_q == LAST_CNT) begin
            timeout_d = 1'b1;
            state_d   = RUN;
          end else begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
            if (busy_cnt_q != '1) busy_cnt_d = busy_cnt_q + BW'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      busy_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              stall_cycles <= '0;
    else if (StallD && stall_cycles != '1)   stall_cycles <= stall_cycles + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_c_hazard_controller.sv
// Scoreboard bench for c_hazard_controller: a rule-level model predicts each cycle's
// outputs, a monitor compares them on the falling edge.
module tb_c_hazard_controller;

  localparam int MC_T  = 8;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwe_w_e, rwe_m, rwe_w, loadm, br, mcs, done;
  } stim_t;

  typedef struct packed {
    logic sf, sd, se, fd, fe, fm;
    logic [1:0] fa, fb;
    logic go, tmo;
    logic [CNT_W-1:0] sc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWE_W_E, RegWE_M, RegWE_W, LoadM, branch_taken_E, mc_start_E, mc_done;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, mc_go, mc_timeout;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] sc_act;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles;
  assign sc_act = stall_cycles;
`else
  assign sc_act = '0;
`endif

  c_hazard_controller #(.MC_TIMEOUT(MC_T), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWE_W_E(RegWE_W_E), .RegWE_M(RegWE_M), .RegWE_W(RegWE_W), .LoadM(LoadM),
    .branch_taken_E(branch_taken_E), .mc_start_E(mc_start_E), .mc_done(mc_done),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mc_go(mc_go), .mc_timeout(mc_timeout)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference state: whether the multi-cycle unit is outstanding, how long, etc.
  bit m_busy, n_busy;
  int m_waited, n_waited;
  bit m_tmo, n_tmo;
  int m_stalls, n_stalls;

  function automatic logic [1:0] src_for(input int rs, input stim_t s);
    if (rs == 0) return 2'b00;
    if (s.rwe_m && !s.loadm && int'(s.rdm) == rs) return 2'b10;
    if (s.rwe_w && int'(s.rdw) == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    bit   dep_d, dep_e;
    e = '0;
    n_busy = m_busy; n_waited = m_waited; n_tmo = m_tmo; n_stalls = m_stalls;
    if (!s.rst_n) begin
      n_busy = 0; n_waited = 0; n_tmo = 0; n_stalls = 0;
      return e;
    end
    e.tmo = m_tmo;
`ifdef HAZ_PERF_CNT_EN
    e.sc = CNT_W'(m_stalls);
`endif
    e.fa = src_for(int'(s.rs1e), s);
    e.fb = src_for(int'(s.rs2e), s);
    dep_d = s.rwe_w_e && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
    dep_e = s.loadm && s.rwe_m && s.rdm != 0 && (s.rdm == s.rs1e || s.rdm == s.rs2e);
    if (!m_busy) begin
      if (s.br) begin
        e.fd = 1; e.fe = 1;
      end else if (dep_e) begin
        {e.sf, e.sd, e.se, e.fm} = 4'b1111;
      end else if (s.mcs) begin
        {e.sf, e.sd, e.se, e.fm} = 4'b1111;
        e.go = 1; n_busy = 1; n_waited = 0;
      end else if (dep_d) begin
        e.sf = 1; e.sd = 1; e.fe = 1;
      end
    end else begin
      // m_waited counts busy cycles already spent; this is busy cycle m_waited+1.
      if (s.done) n_busy = 0;
      else if (m_waited + 1 >= MC_T) begin
        n_busy = 0; n_tmo = 1;
      end else begin
        {e.sf, e.sd, e.se, e.fm} = 4'b1111;
        n_waited = m_waited + 1;
      end
    end
    if (e.sd && m_stalls < (2**CNT_W) - 1) n_stalls = m_stalls + 1;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk);
    m_busy = n_busy; m_waited = n_waited; m_tmo = n_tmo; m_stalls = n_stalls;
    #1;
    reset = s.rst_n;
    Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
    RdE = s.rde; RdM = s.rdm; RdW = s.rdw;
    RegWE_W_E = s.rwe_w_e; RegWE_M = s.rwe_m; RegWE_W = s.rwe_w; LoadM = s.loadm;
    branch_taken_E = s.br; mc_start_E = s.mcs; mc_done = s.done;
    e = predict(s);
    exp_q.push_back(e);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  always @(negedge clk) begin
    exp_t e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{sf: StallF, sd: StallD, se: StallE, fd: FlushD, fe: FlushE, fm: FlushM,
            fa: ForwardAE, fb: ForwardBE, go: mc_go, tmo: mc_timeout, sc: sc_act};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs @cycle %0d: got sf%b sd%b se%b fd%b fe%b fm%b fa%b fb%b go%b tmo%b sc%0d, expected sf%b sd%b se%b fd%b fe%b fm%b fa%b fb%b go%b tmo%b sc%0d",
                 cyc, a.sf, a.sd, a.se, a.fd, a.fe, a.fm, a.fa, a.fb, a.go, a.tmo, a.sc,
                 e.sf, e.sd, e.se, e.fd, e.fe, e.fm, e.fa, e.fb, e.go, e.tmo, e.sc);
      end
    end
  end

  initial begin
    stim_t s;
    m_busy = 0; m_waited = 0; m_tmo = 0; m_stalls = 0;
    n_busy = 0; n_waited = 0; n_tmo = 0; n_stalls = 0;
    reset = 1'b0;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWE_W_E, RegWE_M, RegWE_W, LoadM, branch_taken_E, mc_start_E, mc_done} = '0;

    s = idle(); s.rst_n = 1'b0; s.rdm = 5'd3; s.rwe_m = 1'b1; s.rs1e = 5'd3;
    apply(s); apply(s);
    apply(idle());

    // Load-use: luD cycle, then luE cycle, then forward from W.
    s = idle(); s.rwe_w_e = 1; s.rde = 5'd5; s.rs1d = 5'd5; apply(s);
    s = idle(); s.loadm = 1; s.rwe_m = 1; s.rdm = 5'd5; s.rs1e = 5'd5; apply(s);
    s = idle(); s.rwe_w = 1; s.rdw = 5'd5; s.rs1e = 5'd5; apply(s);

    // Forwarding priority and x0.
    s = idle(); s.rwe_m = 1; s.rdm = 5'd7; s.rwe_w = 1; s.rdw = 5'd7; s.rs1e = 5'd7; apply(s);
    s.rdm = 5'd0; apply(s);
    s.rdw = 5'd0; s.rs2e = 5'd0; apply(s);

    // Branch beats a load-use in D.
    s = idle(); s.br = 1; s.rwe_w_e = 1; s.rde = 5'd9; s.rs2d = 5'd9; apply(s);

    // Multi-cycle op completing after 5 cycles.
    s = idle(); s.mcs = 1; apply(s);
    repeat (4) apply(s);
    s.done = 1; apply(s);
    apply(idle());

    // Timeout, sticky flag, then reset clears it.
    s = idle(); s.mcs = 1; apply(s);
    repeat (MC_T) apply(s);
    repeat (3) apply(idle());
    s = idle(); s.rst_n = 0; apply(s);
    apply(idle());

    // Reset mid-busy with mc_start_E held.
    s = idle(); s.mcs = 1; apply(s); apply(s); apply(s);
    s.rst_n = 0; apply(s);
    s.rst_n = 1; s.mcs = 0; apply(s);
    s.mcs = 1; apply(s);
    s.done = 1; s.mcs = 0; apply(s);
    s = idle(); s.done = 1; apply(s);

    // Randomized traffic with small register numbers to force matches.
    for (int i = 0; i < 1500; i++) begin
      s.rst_n   = ($urandom_range(0, 79) != 0);
      s.rs1d    = 5'($urandom_range(0, 3));
      s.rs2d    = 5'($urandom_range(0, 3));
      s.rs1e    = 5'($urandom_range(0, 3));
      s.rs2e    = 5'($urandom_range(0, 3));
      s.rde     = 5'($urandom_range(0, 3));
      s.rdm     = 5'($urandom_range(0, 3));
      s.rdw     = 5'($urandom_range(0, 3));
      s.rwe_w_e = 1'($urandom_range(0, 1));
      s.rwe_m   = 1'($urandom_range(0, 1));
      s.rwe_w   = 1'($urandom_range(0, 1));
      s.loadm   = ($urandom_range(0, 3) == 0);
      s.br      = ($urandom_range(0, 7) == 0);
      s.mcs     = ($urandom_range(0, 5) == 0);
      s.done    = ($urandom_range(0, 9) == 0);
      apply(s);
    end

    @(posedge clk);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/c_hazard_controller.md
Name: c_hazard_controller

Overview:
- Hazard and sequencing controller for the five-stage core.
- Drives the stall/flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the forwarding muxes.
- Sequences a multi-cycle execute unit by holding the ID/EX register while the unit is busy, with timeout recovery.
- Sits beside the control pipeline registers and takes their E/M/W-stage control outputs.

Parameters:
- MC_TIMEOUT, 64: maximum cycles spent in MC_BUSY before forced release.
- CNT_W, 16: width of the performance counter (optional feature only).

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous reset, active-low
- Rs1D, Rs2D  input  5  source registers of the instruction in D
- Rs1E, Rs2E  input  5  source registers of the instruction in E
- RdE, RdM, RdW  input  5  destination registers in E/M/W
- RegWE_W_E  input  1  E-stage instruction writes rd with a result ready only at W (load)
- RegWE_M, RegWE_W  input  1  M-/W-stage instruction writes rd
- LoadM  input  1  M-stage instruction is a load (result not yet available)
- branch_taken_E  input  1  branch/jump in E resolved taken
- mc_start_E  input  1  E-stage instruction needs the multi-cycle unit
- mc_done  input  1  multi-cycle result valid, single-cycle pulse
- StallF, StallD, StallE  output  1  hold PC / IF-ID / ID-EX
- FlushD, FlushE, FlushM  output  1  bubble into IF-ID / ID-EX / EX-MEM
- ForwardAE, ForwardBE  output  2  00 = register file, 01 = W result, 10 = M result
- mc_go  output  1  start pulse to the multi-cycle unit
- mc_timeout  output  1  sticky; set when MC_TIMEOUT expires

Behaviour:
- Reset (reset low, asynchronous): state RUN, busy counter 0, mc_timeout 0; every output reads 0 while reset is low.
- Forwarding (combinational, per operand; Rs1E shown):
  - 10 if RegWE_M && !LoadM && RdM!=0 && RdM==Rs1E.
  - else 01 if RegWE_W && RdW!=0 && RdW==Rs1E.
  - else 00.
  - M has priority over W. Rs2E drives ForwardBE with the same rule.
- Hazard terms (combinational):
  - luD = RegWE_W_E && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - luE = LoadM && RegWE_M && RdM!=0 && (RdM==Rs1E || RdM==Rs2E).
- RUN state, first match wins:
  1. branch_taken_E: FlushD=1, FlushE=1, no stalls.
  2. luE: StallF=StallD=StallE=1, FlushM=1.
  3. mc_start_E: mc_go=1 for exactly this cycle, StallF/D/E=1, FlushM=1; next state MC_BUSY, counter cleared.
  4. luD: StallF=StallD=1, FlushE=1.
  5. Otherwise all outputs 0.
- Net effect: a load followed by a dependent instruction costs exactly 2 bubbles (luD cycle, then luE cycle).
- MC_BUSY state:
  - StallF/D/E=1, FlushM=1, counter increments each cycle; branch/load terms are ignored.
  - mc_done=1: all stalls and flushes 0 in that cycle so E advances at the edge with the result; next state RUN.
  - Counter reaches MC_TIMEOUT-1 without mc_done: mc_timeout set (sticky until reset), stalls released that cycle, next state RUN.
  - mc_done in the same cycle as expiry: treated as done, mc_timeout not set.
- mc_go fires only on a RUN-state cycle and never twice for one instruction. mc_done arriving in RUN is ignored.
- Reset mid-MC_BUSY: returns to RUN; mc_go is not reissued until mc_start_E is seen in RUN.
- Counter width is clog2(MC_TIMEOUT)+1 and never wraps.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined:
  - Adds output stall_cycles [CNT_W-1:0], reset to 0.
  - Increments once per cycle that StallD=1.
  - Saturates at all-ones.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- lw x5 in E (RegWE_W_E=1, RdE=5), add with Rs1D=5 -> cycle 1: StallF/D=1, FlushE=1; cycle 2 (load in M, LoadM=1): StallF/D/E=1, FlushM=1; cycle 3: ForwardAE=01, no stalls.
- RdM=7, RegWE_M=1, LoadM=0; RdW=7, RegWE_W=1; Rs1E=7 -> ForwardAE=10. Set RdM=0 -> ForwardAE=01. Rs2E=0 with RdW=0 -> ForwardBE=00.
- branch_taken_E=1 together with luD true -> FlushD=FlushE=1, StallF=StallD=0.
- mc_start_E=1 -> mc_go pulse for 1 cycle. mc_done raised 5 cycles later -> StallE=1 for 5 cycles, 0 on the mc_done cycle; mc_go stays 0 throughout.
- MC_TIMEOUT=8, mc_done never raised -> mc_timeout=1 after 8 busy cycles, stalls released; mc_timeout held until reset goes low.
- Reset low mid-MC_BUSY -> all outputs 0 immediately, state RUN after release. With HAZ_PERF_CNT_EN, stall_cycles reads 0 after reset and 3 after a 3-cycle stall.
